// File: rtl/exu_oitf.sv
// Outstanding Instruction Track FIFO: allocates tags for long-pipe instructions and flags RAW/WAW hazards.
// Optional macro OITF_RET_BYPASS_EN lets a retiring entry free its slot and drop out of matching in the same cycle.
`ifndef ITAG_WIDTH
`define ITAG_WIDTH 2
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module exu_oitf #(
  parameter int OITF_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      disp_oitf_ena,
  output logic                      disp_oitf_ready,
  output logic [`ITAG_WIDTH-1:0]    disp_oitf_ptr,
  input  logic                      disp_oitf_rs1en,
  input  logic                      disp_oitf_rs2en,
  input  logic                      disp_oitf_rdwen,
  input  logic [`RFIDX_WIDTH-1:0]   disp_oitf_rs1idx,
  input  logic [`RFIDX_WIDTH-1:0]   disp_oitf_rs2idx,
  input  logic [`RFIDX_WIDTH-1:0]   disp_oitf_rdidx,
  output logic                      oitfrd_match_disprs1,
  output logic                      oitfrd_match_disprs2,
  output logic                      oitfrd_match_disprd,
  output logic                      oitf_empty,
  input  logic                      oitf_ret_ena,
  output logic [`ITAG_WIDTH-1:0]    oitf_ret_ptr,
  output logic                      oitf_ret_rdwen,
  output logic [`RFIDX_WIDTH-1:0]   oitf_ret_rdidx
);

  localparam int IW = `ITAG_WIDTH;
  localparam int RW = `RFIDX_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(OITF_DEPTH - 1);

  logic [OITF_DEPTH-1:0] valid;
  logic [OITF_DEPTH-1:0] rdwen_q;
  logic [RW-1:0]         rdidx_q [OITF_DEPTH];
  logic [IW-1:0]         alloc_idx, ret_idx;
  logic                  alloc_wrap, ret_wrap;
  logic                  full, alloc_fire, ret_fire;
  logic [OITF_DEPTH-1:0] ret_sel, match_excl;

  assign oitf_empty = (alloc_idx == ret_idx) && (alloc_wrap == ret_wrap);
  assign full       = (alloc_idx == ret_idx) && (alloc_wrap != ret_wrap);

`ifdef OITF_RET_BYPASS_EN
  assign disp_oitf_ready = ~full | oitf_ret_ena;
  assign match_excl      = oitf_ret_ena ? ret_sel : '0;
`else
  assign disp_oitf_ready = ~full;
  assign match_excl      = '0;
`endif

  assign alloc_fire    = disp_oitf_ena & disp_oitf_ready;
  assign ret_fire      = oitf_ret_ena & ~oitf_empty;
  assign disp_oitf_ptr = alloc_idx;
  assign oitf_ret_ptr  = ret_idx;

  always_comb begin
    ret_sel              = '0;
    oitf_ret_rdwen       = 1'b0;
    oitf_ret_rdidx       = '0;
    oitfrd_match_disprs1 = 1'b0;
    oitfrd_match_disprs2 = 1'b0;
    oitfrd_match_disprd  = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (ret_idx == IW'(i)) begin
        ret_sel[i]     = 1'b1;
        oitf_ret_rdwen = rdwen_q[i];
        oitf_ret_rdidx = rdidx_q[i];
      end
    end
    // Only registered entries can match; a same-cycle allocation is never seen here.
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (valid[i] && rdwen_q[i] && !match_excl[i]) begin
        if (disp_oitf_rs1en && (rdidx_q[i] == disp_oitf_rs1idx)) oitfrd_match_disprs1 = 1'b1;
        if (disp_oitf_rs2en && (rdidx_q[i] == disp_oitf_rs2idx)) oitfrd_match_disprs2 = 1'b1;
        if (disp_oitf_rdwen && (rdidx_q[i] == disp_oitf_rdidx))  oitfrd_match_disprd  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= '0;
      rdwen_q    <= '0;
      alloc_idx  <= '0;
      alloc_wrap <= 1'b0;
      ret_idx    <= '0;
      ret_wrap   <= 1'b0;
      for (int i = 0; i < OITF_DEPTH; i++) rdidx_q[i] <= '0;
    end else begin
      if (alloc_fire) begin
        if (alloc_idx == LAST_IDX) begin
          alloc_idx  <= '0;
          alloc_wrap <= ~alloc_wrap;
        end else begin
          alloc_idx <= alloc_idx + 1'b1;
        end
      end
      if (ret_fire) begin
        if (ret_idx == LAST_IDX) begin
          ret_idx  <= '0;
          ret_wrap <= ~ret_wrap;
        end else begin
          ret_idx <= ret_idx + 1'b1;
        end
      end
      // With bypass a full FIFO may retire and refill one slot; the new allocation wins.
      for (int i = 0; i < OITF_DEPTH; i++) begin
        if (alloc_fire && (alloc_idx == IW'(i))) begin
          valid[i]   <= 1'b1;
          rdwen_q[i] <= disp_oitf_rdwen;
          rdidx_q[i] <= disp_oitf_rdidx;
        end else if (ret_fire && (ret_idx == IW'(i))) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule
